// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop filter stage.
// Pixel width, FSM state codes and counter sizing.
package crop_pkg;

    localparam int PIX_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream output register.
// Holds data and last stable while the consumer stalls.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         din_last,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         tlast
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= din;
            tlast  <= din_last;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/crop_filter.sv
// Crops a raster pixel stream to a fixed window at a run-time offset
// and tracks the largest forwarded pixel for the normalisation stage.
module crop_filter
    import crop_pkg::*;
#(
    parameter int IN_ROWS  = 8,
    parameter int IN_COLS  = 8,
    parameter int OUT_ROWS = 4,
    parameter int OUT_COLS = 4
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_ready,
    output logic                       ap_idle,
    input  logic [cnt_w(IN_ROWS)-1:0]  crop_row_start,
    input  logic [cnt_w(IN_COLS)-1:0]  crop_col_start,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIX_W-1:0]           s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIX_W-1:0]           m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [PIX_W-1:0]           max_pixel,
    output logic                       frame_err
);

    localparam int RW = cnt_w(IN_ROWS);
    localparam int CW = cnt_w(IN_COLS);

    localparam logic [RW-1:0] ROW_LAST  = RW'(IN_ROWS - 1);
    localparam logic [RW-1:0] ROW_CLAMP = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [RW-1:0] ROW_SPAN  = RW'(OUT_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IN_COLS - 1);
    localparam logic [CW-1:0] COL_CLAMP = CW'(IN_COLS - OUT_COLS);
    localparam logic [CW-1:0] COL_SPAN  = CW'(OUT_COLS - 1);

    state_t           state;
    logic [RW-1:0]    row;
    logic [RW-1:0]    row_start;
    logic [RW-1:0]    row_end;
    logic [CW-1:0]    col;
    logic [CW-1:0]    col_start;
    logic [CW-1:0]    col_end;
    logic [PIX_W-1:0] max_r;
    logic             in_win;
    logic             in_hs;
    logic             load;
    logic             col_wrap;
    logic             last_pix;
    logic             win_last;

    // Clamped offsets keep the window end inside the frame, so no overflow.
    assign row_end  = row_start + ROW_SPAN;
    assign col_end  = col_start + COL_SPAN;
    assign in_win   = (row >= row_start) && (row <= row_end) &&
                      (col >= col_start) && (col <= col_end);
    assign col_wrap = (col == COL_LAST);
    assign last_pix = (row == ROW_LAST) && col_wrap;
    assign win_last = (row == row_end) && (col == col_end);

    // Dropped pixels never wait on the output side.
    assign s_axis_tready = (state == RUN) &&
                           (!in_win || !m_axis_tvalid || m_axis_tready);
    assign in_hs = s_axis_tvalid && s_axis_tready;
    assign load  = in_hs && in_win;

    assign ap_done   = (state == DONE);
    assign ap_ready  = (state == IDLE);
    assign ap_idle   = (state == IDLE);
    assign max_pixel = (max_r == '0) ? PIX_W'(1) : max_r;

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            row_start <= '0;
            col_start <= '0;
            max_r     <= '0;
            frame_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ap_start) begin
                        state     <= RUN;
                        row_start <= (crop_row_start > ROW_CLAMP) ?
                                     ROW_CLAMP : crop_row_start;
                        col_start <= (crop_col_start > COL_CLAMP) ?
                                     COL_CLAMP : crop_col_start;
                        row       <= '0;
                        col       <= '0;
                        max_r     <= '0;
                        frame_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        col <= col_wrap ? '0 : col + CW'(1);
                        if (col_wrap)
                            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                        if (load && (s_axis_tdata > max_r))
                            max_r <= s_axis_tdata;
                        if (s_axis_tlast != col_wrap)
                            frame_err <= 1'b1;
                        if (last_pix)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_axis_tvalid || m_axis_tready)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .W (PIX_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (s_axis_resetn),
        .load     (load),
        .din      (s_axis_tdata),
        .din_last (win_last),
        .tready   (m_axis_tready),
        .tvalid   (m_axis_tvalid),
        .tdata    (m_axis_tdata),
        .tlast    (m_axis_tlast)
    );

endmodule

// File: doc/crop_filter.md
Name: crop_filter

Overview:
- Upstream neighbour of the normalization reader. Consumes the full camera frame as an 8-bit pixel AXI-Stream, raster order.
- Forwards only the pixels inside an OUT_ROWS x OUT_COLS window at a run-time row/col offset.
- Tracks the maximum cropped pixel and presents it as the normalization denominator.
- Signals frame completion with ap_done; the normalization stage consumes it as its crop-filter-done input.

Parameters:
- IN_ROWS, 8, full-frame row count
- IN_COLS, 8, full-frame column count
- OUT_ROWS, 4, cropped row count (<= IN_ROWS)
- OUT_COLS, 4, cropped column count (<= IN_COLS)

Ports:
- clk  in  1  single clock
- s_axis_resetn  in  1  asynchronous active-low reset
- ap_start  in  1  begin one frame; sampled only in IDLE
- ap_done  out  1  one-cycle pulse: frame consumed and all cropped pixels delivered
- ap_ready  out  1  high in IDLE
- ap_idle  out  1  high in IDLE
- crop_row_start  in  $clog2(IN_ROWS)  window top row; latched on accepted ap_start
- crop_col_start  in  $clog2(IN_COLS)  window left column; latched on accepted ap_start
- s_axis_tvalid / s_axis_tready  in/out  1  input handshake
- s_axis_tdata  in  8  pixel
- s_axis_tlast  in  1  end of input line
- m_axis_tvalid / m_axis_tready  out/in  1  output handshake
- m_axis_tdata  out  8  cropped pixel
- m_axis_tlast  out  1  last pixel of cropped frame
- max_pixel  out  8  max cropped pixel, floored to 1; stable from ap_done until next accepted ap_start
- frame_err  out  1  sticky tlast mismatch flag; cleared on accepted ap_start

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all counters 0; max register 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - ap_done=0, ap_ready=1, ap_idle=1, s_axis_tready=0, frame_err=0, max_pixel=1.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: ap_start latches offsets, clears row/col counters, max register and frame_err, then moves to RUN. s_axis_tready=0.
  - RUN: accepting input. The last input beat (row=IN_ROWS-1, col=IN_COLS-1) moves to DRAIN.
  - DRAIN: s_axis_tready=0; waits until the output register empties, then moves to DONE.
  - DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_start outside IDLE is ignored.
- Offset clamp at latch time:
  - row_start = min(crop_row_start, IN_ROWS-OUT_ROWS)
  - col_start = min(crop_col_start, IN_COLS-OUT_COLS)
- Window test: in_win = row in [row_start, row_start+OUT_ROWS-1] AND col in [col_start, col_start+OUT_COLS-1].
- Input ready: s_axis_tready = RUN && (!in_win || !m_axis_tvalid || m_axis_tready). Out-of-window pixels are consumed and dropped, never stalled by the output side.
- Output register, single stage, latency 1:
  - An accepted in-window beat loads m_axis_tdata and sets m_axis_tvalid on the next edge.
  - m_axis_tvalid clears on an output handshake with no new load.
  - Simultaneous output handshake and new load keeps tvalid=1 with the new data.
  - Output data/last are held stable while tvalid && !tready.
- m_axis_tlast=1 on the beat from row_start+OUT_ROWS-1, col_start+OUT_COLS-1.
- Counters: col wraps at IN_COLS-1 and increments row; both advance only on an input handshake.
- Max tracking: on each accepted in-window beat, max <= (tdata > max) ? tdata : max. max_pixel = (max==0) ? 1 : max, so the downstream reciprocal never sees 0.
- frame_err is set when either occurs on an input handshake:
  - s_axis_tlast=1 with col != IN_COLS-1
  - s_axis_tlast=0 with col == IN_COLS-1
- Counting uses the internal counters only; tlast never resynchronises them.
- Reset mid-frame: immediate return to IDLE; any pending output beat is discarded.
- Throughput: 1 pixel/clk with no backpressure; ap_done arrives 2 cycles after the last input beat.

Decomposition:
- Shared package crop_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - PIX_W=8
  - count-width helper localparams
- One natural sub-module: axis_out_reg, the one-deep output register with tvalid/tready/tdata/tlast hold logic. It is reusable by other stages.
- Counters, clamp and max tracking stay in the top level.

Test Plan:
- Basic crop: params 8x8 -> 4x4, offsets (2,3), pixel = row*16+col, no backpressure. Expect 16 output beats 0x23..0x26, 0x33..0x56 in raster order; tlast only on 0x56; max_pixel=0x56; one ap_done pulse; frame_err=0.
- Backpressure: same frame, m_axis_tready toggled 1-of-3 cycles. Expect the identical 16-beat sequence; tdata stable while stalled; no out-of-window stall, so the 64 input beats finish only as gated by in-window pixels.
- Clamp: offsets (7,7). Expect window (4,4): first beat 0x44, last 0x77 with tlast, max_pixel=0x77.
- All-zero frame, offsets (0,0). Expect 16 zero beats and max_pixel=1.
- Protocol: tlast asserted at col 5 of row 1. Expect frame_err=1 and still 16 correct beats. Next ap_start clears frame_err. ap_start pulsed during RUN is ignored.
- Reset mid-frame: deassert s_axis_resetn after 20 input beats. Expect immediate m_axis_tvalid=0 and ap_idle=1. A fresh frame then produces the correct 16 beats.
